conv_mem_responder: RTL and testbench

- Memory-side responder for the convolution engine's memory interface (index / wrEn / write data / read data).
- Holds a DEPTH x WIDTH word array serving the engine's reads and writes.
- Gives a host port a command FSM: preload the image and filter (LOAD), launch the engine (RUN), stream results back out (DUMP).
- Sits beside the convolution top level; the engine is the initiator, this block answers.

---
 rtl/conv_mem_responder.sv | 152 +++++++++++++++
 tb/tb_conv_mem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Word memory shared by the convolution engine and a host command port.
// The host preloads data (LOAD), launches the engine (RUN) and streams results out (DUMP).
module conv_mem_responder #(
    parameter int unsigned LEN   = 9,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [LEN-1:0]   cmd_base,
    input  logic [LEN:0]     cmd_count,
    output logic             cmd_err,
    input  logic             host_wvalid,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_wready,
    output logic             host_rvalid,
    output logic [WIDTH-1:0] host_rdata,
    input  logic             host_rready,
    input  logic [LEN-1:0]   eng_index,
    input  logic             eng_wrEn,
    input  logic [WIDTH-1:0] eng_wdata,
    output logic [WIDTH-1:0] eng_rdata,
    output logic             eng_start,
    input  logic             eng_done,
    output logic             busy
);

    localparam int unsigned CW = LEN + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDump} state_e;

    state_e           state_q, state_d;
    logic [LEN-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             mem_we;
    logic [LEN-1:0]   mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign eng_rdata   = mem_q[eng_index];
    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign cmd_err     = err_q;
    assign eng_start   = start_q;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        start_d     = 1'b0;
        err_d       = 1'b0;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = host_wdata;
        host_wready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    ptr_d = cmd_base;
                    cnt_d = cmd_count;
                    case (cmd_op)
                        2'b00: state_d = StLoad;
                        2'b01: begin
                            state_d = StRun;
                            start_d = 1'b1;
                        end
                        2'b10: state_d = StDump;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StLoad: begin
                host_wready = (cnt_q != '0);
                if (host_wvalid && host_wready) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + LEN'(1);
                    cnt_d  = cnt_q - CW'(1);
                end
                if (cnt_d == '0) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (eng_wrEn) begin
                    mem_we    = 1'b1;
                    mem_waddr = eng_index;
                    mem_wdata = eng_wdata;
                end
                // Done raised alongside the launch pulse belongs to a previous job.
                if (!start_q && eng_done) begin
                    state_d = StIdle;
                end
            end
            StDump: begin
                // Fetch whenever the output register is empty or being drained.
                if (!rvalid_q || host_rready) begin
                    if (cnt_q != '0) begin
                        rdata_d  = mem_q[ptr_q];
                        rvalid_d = 1'b1;
                        ptr_d    = ptr_q + LEN'(1);
                        cnt_d    = cnt_q - CW'(1);
                    end else begin
                        rvalid_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed bench for conv_mem_responder: a reference memory plus expected-word queue,
// checked every cycle by one compare process, with literal pins on key values.
module tb_conv_mem_responder;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_base;
    logic [9:0]  cmd_count;
    logic        cmd_err;
    logic        host_wvalid;
    logic [31:0] host_wdata;
    logic        host_wready;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        host_rready;
    logic [8:0]  eng_index;
    logic        eng_wrEn;
    logic [31:0] eng_wdata;
    logic [31:0] eng_rdata;
    logic        eng_start;
    logic        eng_done;
    logic        busy;

    conv_mem_responder #(.LEN(9), .WIDTH(32), .DEPTH(512)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_base   (cmd_base),
        .cmd_count  (cmd_count),
        .cmd_err    (cmd_err),
        .host_wvalid(host_wvalid),
        .host_wdata (host_wdata),
        .host_wready(host_wready),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .host_rready(host_rready),
        .eng_index  (eng_index),
        .eng_wrEn   (eng_wrEn),
        .eng_wdata  (eng_wdata),
        .eng_rdata  (eng_rdata),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] mdl [512];
    bit          known [512];
    logic [31:0] ld_data [512];
    logic [31:0] exp_q [$];

    int          hs_cnt    = 0;
    int          hs_first  = 0;
    int          hs_last   = 0;
    int          start_cnt = 0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, sampled between the input-drive edge and the next active edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                if (known[eng_index]) check("eng_rdata", eng_rdata, mdl[eng_index]);
                if (hold_pend) begin
                    check("hold_rvalid", {31'd0, host_rvalid}, 32'd1);
                    check("hold_rdata", host_rdata, hold_data);
                end
                hold_pend = host_rvalid && !host_rready;
                hold_data = host_rdata;
                if (eng_start) start_cnt++;
                if (host_rvalid && host_rready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL dump_extra: got word %0h expected no word", host_rdata);
                    end else begin
                        check("dump_word", host_rdata, exp_q.pop_front());
                    end
                    if (hs_cnt == 0) hs_first = cyc;
                    hs_last = cyc;
                    hs_cnt++;
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [8:0] base, input int count);
        @(negedge clk);
        check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = base;
        cmd_count = 10'(count);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [8:0] base, input int count);
        send_cmd(2'b00, base, count);
        check("load_busy", {31'd0, busy}, 32'd1);
        if (count == 0) begin
            check("load0_wready", {31'd0, host_wready}, 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < count; i++) begin
            check("load_wready", {31'd0, host_wready}, 32'd1);
            host_wvalid = 1'b1;
            host_wdata  = ld_data[i];
            @(negedge clk);
            mdl[(int'(base) + i) % 512]   = ld_data[i];
            known[(int'(base) + i) % 512] = 1'b1;
        end
        host_wvalid = 1'b0;
        check("load_end_busy", {31'd0, busy}, 32'd0);
        check("load_end_wready", {31'd0, host_wready}, 32'd0);
    endtask

    task automatic do_dump(input logic [8:0] base, input int count, input bit toggle,
                           input bit eng_poke);
        int entry;
        int k;
        exp_q.delete();
        hs_cnt    = 0;
        hold_pend = 1'b0;
        for (int i = 0; i < count; i++) exp_q.push_back(mdl[(int'(base) + i) % 512]);
        send_cmd(2'b10, base, count);
        entry = cyc;
        check("dump_entry_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("dump_entry_busy", {31'd0, busy}, 32'd1);
        if (eng_poke) begin
            eng_wrEn  = 1'b1;
            eng_index = 9'd5;
            eng_wdata = 32'h1234;
        end
        host_rready = toggle ? 1'b0 : 1'b1;
        k = 0;
        if (count == 0) @(negedge clk);
        while (hs_cnt < count && k < 3 * count + 8) begin
            @(negedge clk);
            k++;
            host_rready = toggle ? k[0] : 1'b1;
        end
        check("dump_count", hs_cnt, count);
        check("dump_left", exp_q.size(), 0);
        check("dump_end_busy", {31'd0, busy}, 32'd0);
        check("dump_end_rvalid", {31'd0, host_rvalid}, 32'd0);
        if (count > 0) begin
            check("dump_first_cycle", hs_first, entry + 1);
            check("dump_last_cycle", hs_last, toggle ? entry + 2 * count - 1 : entry + count);
        end
        host_rready = 1'b0;
        eng_wrEn    = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_base    = '0;
        cmd_count   = '0;
        host_wvalid = 1'b0;
        host_wdata  = '0;
        host_rready = 1'b0;
        eng_index   = '0;
        eng_wrEn    = 1'b0;
        eng_wdata   = '0;
        eng_done    = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_wready", {31'd0, host_wready}, 32'd0);
        check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        check("rst_eng_start", {31'd0, eng_start}, 32'd0);
        rst = 1'b1;

        // Basic load, then zero-latency engine reads.
        ld_data[0] = 32'd11; ld_data[1] = 32'd22; ld_data[2] = 32'd33; ld_data[3] = 32'd44;
        do_load(9'd0, 4);
        for (int i = 0; i < 4; i++) begin
            eng_index = 9'(i);
            #1;
            check("eng_read_lit", eng_rdata, 32'd11 * 32'(i + 1));
            @(negedge clk);
        end

        // Wrapping load and a back-pressured dump across the wrap.
        ld_data[0] = 32'hAAAA_0001; ld_data[1] = 32'hBBBB_0002; ld_data[2] = 32'hCCCC_0003;
        do_load(9'd510, 3);
        eng_index = 9'd0;
        #1;
        check("wrap_lit", eng_rdata, 32'hCCCC_0003);
        do_dump(9'd510, 3, 1'b1, 1'b0);

        // Reserved op.
        send_cmd(2'b11, 9'd0, 0);
        check("err_pulse", {31'd0, cmd_err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check("err_clear", {31'd0, cmd_err}, 32'd0);

        do_load(9'd100, 0);
        do_dump(9'd100, 0, 1'b0, 1'b0);

        // RUN with a scripted engine.
        start_cnt = 0;
        send_cmd(2'b01, 9'd0, 0);
        check("run_start", {31'd0, eng_start}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd1);
        eng_done = 1'b1;
        @(negedge clk);
        check("run_start_once", {31'd0, eng_start}, 32'd0);
        check("run_done_ignored", {31'd0, busy}, 32'd1);
        eng_done  = 1'b0;
        eng_wrEn  = 1'b1;
        eng_index = 9'd7;
        eng_wdata = 32'hDEAD;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_count = 10'd1;
        @(negedge clk);
        mdl[7] = 32'hDEAD; known[7] = 1'b1;
        eng_wrEn  = 1'b0;
        cmd_valid = 1'b0;
        check("run_still_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        eng_done  = 1'b1;
        eng_wrEn  = 1'b1;
        eng_index = 9'd8;
        eng_wdata = 32'hBEEF;
        @(negedge clk);
        mdl[8] = 32'hBEEF; known[8] = 1'b1;
        eng_done = 1'b0;
        eng_wrEn = 1'b0;
        check("run_end_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("run_no_queue", {31'd0, busy}, 32'd0);
        eng_index = 9'd7;
        #1;
        check("run_write_lit", eng_rdata, 32'hDEAD);
        check("run_start_count", start_cnt, 1);
        do_dump(9'd7, 2, 1'b0, 1'b0);

        // Full-depth load, ignored engine writes in IDLE and DUMP, full-depth dump.
        for (int i = 0; i < 512; i++) ld_data[i] = 32'h1000_0000 + 32'(i * 7);
        do_load(9'd0, 512);
        @(negedge clk);
        eng_wrEn  = 1'b1;
        eng_index = 9'd5;
        eng_wdata = 32'h1234;
        repeat (2) @(negedge clk);
        eng_wrEn = 1'b0;
        do_dump(9'd0, 512, 1'b0, 1'b1);
        do_dump(9'd5, 1, 1'b0, 1'b0);

        // Reset in the middle of a load.
        ld_data[0] = 32'h5100; ld_data[1] = 32'h5101; ld_data[2] = 32'h5102;
        ld_data[3] = 32'h5103;
        send_cmd(2'b00, 9'd20, 4);
        for (int i = 0; i < 2; i++) begin
            host_wvalid = 1'b1;
            host_wdata  = ld_data[i];
            @(negedge clk);
            mdl[20 + i] = ld_data[i];
        end
        host_wvalid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_wready", {31'd0, host_wready}, 32'd0);
        check("mid_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        eng_index = 9'd20;
        #1;
        check("mid_rst_lit", eng_rdata, 32'h5100);
        do_dump(9'd20, 4, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
